// File: rtl/aggregate_writer_pkg.sv
// -----------------------------------------------------------------------------
// aggregate_writer_pkg
// Shared constants, FSM state encoding, register-bank address map and the
// byte-address helper used by the aggregate writer.
// Optional feature macro used by this slice: AGG_WRITER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package aggregate_writer_pkg;

    localparam int MEM_DEPTH   = 1024;  // bytes; addresses wrap modulo this
    localparam int MEM_WIDTH   = 8;     // memory data width
    localparam int WORD_WIDTH  = 16;    // input word and address width
    localparam int COUNT_WIDTH = 8;     // word_count width

    // Register-bank address map
    localparam logic [WORD_WIDTH-1:0] REG_FLAG_ADDR = 16'h0000;  // flag word

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_WORD = 3'd1,
        ST_WR_LO     = 3'd2,
        ST_WR_HI     = 3'd3,
        ST_DONE      = 3'd4,
        ST_CS_LO     = 3'd5,
        ST_CS_HI     = 3'd6
    } state_e;

    // 16-bit add, reduced modulo MEM_DEPTH, zero-extended back to 16 bits.
    function automatic logic [WORD_WIDTH-1:0] mem_addr(
        input logic [WORD_WIDTH-1:0] base,
        input logic [WORD_WIDTH-1:0] offset
    );
        logic [WORD_WIDTH-1:0] raw;
        raw = base + offset;
        return raw % WORD_WIDTH'(MEM_DEPTH);
    endfunction

endpackage

// File: rtl/aggregate_writer_if.sv
// -----------------------------------------------------------------------------
// aggregate_writer_if
// Request/handshake/memory-write bundle of the aggregate writer.
//   master : the requester (drives start, base_addr, word_count, data_in,
//            data_valid; observes data_ready, address, data_out, wr_en,
//            busy, done)
//   slave  : the writer itself (mirror directions)
// -----------------------------------------------------------------------------
interface aggregate_writer_if;

    logic                                        start;
    logic [aggregate_writer_pkg::WORD_WIDTH-1:0]  base_addr;
    logic [aggregate_writer_pkg::COUNT_WIDTH-1:0] word_count;
    logic [aggregate_writer_pkg::WORD_WIDTH-1:0]  data_in;
    logic                                        data_valid;
    logic                                        data_ready;
    logic [aggregate_writer_pkg::WORD_WIDTH-1:0]  address;
    logic [aggregate_writer_pkg::MEM_WIDTH-1:0]   data_out;
    logic                                        wr_en;
    logic                                        busy;
    logic                                        done;

    modport master (
        output start, base_addr, word_count, data_in, data_valid,
        input  data_ready, address, data_out, wr_en, busy, done
    );

    modport slave (
        input  start, base_addr, word_count, data_in, data_valid,
        output data_ready, address, data_out, wr_en, busy, done
    );

endinterface

// File: rtl/aggregate_writer_checksum16.sv
// -----------------------------------------------------------------------------
// checksum16
// 16-bit wrap-around accumulator of accepted words.
//   clock   : rising-edge clock
//   nrst    : synchronous active-low reset (sum -> 0)
//   clear_i : zero the sum (start of a run)
//   acc_i   : add word_i into the sum
//   word_i  : word to accumulate
//   sum_o   : current sum
// Only exists when AGG_WRITER_CHECKSUM_EN is defined; the default build has
// no accumulator at all.
// -----------------------------------------------------------------------------
`ifdef AGG_WRITER_CHECKSUM_EN
module checksum16
    import aggregate_writer_pkg::*;
(
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  clear_i,
    input  logic                  acc_i,
    input  logic [WORD_WIDTH-1:0] word_i,
    output logic [WORD_WIDTH-1:0] sum_o
);

    logic [WORD_WIDTH-1:0] sum_q;
    logic [WORD_WIDTH-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (acc_i) begin
            sum_d = sum_q + word_i;  // carry out is dropped: wrap-around sum
        end
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule
`endif

// File: rtl/aggregate_writer.sv
// -----------------------------------------------------------------------------
// aggregate_writer
// Accepts a run of 16-bit words over a valid/ready handshake and stores each
// as two consecutive bytes (low byte first) starting at a latched base
// address in the 8-bit data memory, then raises done.
//   clock : rising-edge clock
//   nrst  : synchronous active-low reset
//   bus   : aggregate_writer_if.slave (start/base_addr/word_count request,
//           data_in/data_valid/data_ready handshake, address/data_out/wr_en
//           memory write port, busy/done status)
// Optional feature: AGG_WRITER_CHECKSUM_EN appends the 16-bit wrap-around
// sum of all accepted words as two more bytes after the payload.
// -----------------------------------------------------------------------------
module aggregate_writer
    import aggregate_writer_pkg::*;
(
    input  logic              clock,
    input  logic              nrst,
    aggregate_writer_if.slave bus
);

    state_e                 state_q, state_d;
    logic [WORD_WIDTH-1:0]  base_q,  base_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] idx_q,   idx_d;
    logic [WORD_WIDTH-1:0]  word_q,  word_d;

    // Byte offsets of the current word and of the checksum slot.
    logic [WORD_WIDTH-1:0]  word_offset;
    logic [WORD_WIDTH-1:0]  tail_offset;
    logic                   last_word;

    assign word_offset = {{(WORD_WIDTH-COUNT_WIDTH-1){1'b0}}, idx_q,   1'b0};
    assign tail_offset = {{(WORD_WIDTH-COUNT_WIDTH-1){1'b0}}, count_q, 1'b0};
    assign last_word   = (idx_q + 8'd1) == count_q;

`ifdef AGG_WRITER_CHECKSUM_EN
    logic                  cs_clear;
    logic                  cs_acc;
    logic [WORD_WIDTH-1:0] cs_sum;

    checksum16 u_checksum16 (
        .clock   (clock),
        .nrst    (nrst),
        .clear_i (cs_clear),
        .acc_i   (cs_acc),
        .word_i  (bus.data_in),
        .sum_o   (cs_sum)
    );
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        word_d  = word_q;

        bus.data_ready = 1'b0;
        bus.address    = '0;
        bus.data_out   = '0;
        bus.wr_en      = 1'b0;
        bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        bus.done       = (state_q == ST_DONE);
`ifdef AGG_WRITER_CHECKSUM_EN
        cs_clear = 1'b0;
        cs_acc   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    count_d = bus.word_count;
                    idx_d   = '0;
`ifdef AGG_WRITER_CHECKSUM_EN
                    cs_clear = 1'b1;
                    state_d  = (bus.word_count == '0) ? ST_CS_LO : ST_WAIT_WORD;
`else
                    state_d  = (bus.word_count == '0) ? ST_DONE : ST_WAIT_WORD;
`endif
                end
            end

            ST_WAIT_WORD: begin
                bus.data_ready = 1'b1;
                if (bus.data_valid) begin
                    word_d  = bus.data_in;
                    state_d = ST_WR_LO;
`ifdef AGG_WRITER_CHECKSUM_EN
                    cs_acc  = 1'b1;
`endif
                end
            end

            ST_WR_LO: begin
                bus.wr_en    = 1'b1;
                bus.address  = mem_addr(base_q, word_offset);
                bus.data_out = word_q[7:0];
                state_d      = ST_WR_HI;
            end

            ST_WR_HI: begin
                bus.wr_en    = 1'b1;
                bus.address  = mem_addr(base_q, word_offset | 16'h0001);
                bus.data_out = word_q[15:8];
                idx_d        = idx_q + 8'd1;
                if (last_word) begin
`ifdef AGG_WRITER_CHECKSUM_EN
                    state_d = ST_CS_LO;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_WAIT_WORD;
                end
            end

`ifdef AGG_WRITER_CHECKSUM_EN
            ST_CS_LO: begin
                bus.wr_en    = 1'b1;
                bus.address  = mem_addr(base_q, tail_offset);
                bus.data_out = cs_sum[7:0];
                state_d      = ST_CS_HI;
            end

            ST_CS_HI: begin
                bus.wr_en    = 1'b1;
                bus.address  = mem_addr(base_q, tail_offset | 16'h0001);
                bus.data_out = cs_sum[15:8];
                state_d      = ST_DONE;
            end
`endif

            ST_DONE: begin
                // done is held until the requester drops start.
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_aggregate_writer.sv
// -----------------------------------------------------------------------------
// tb_aggregate_writer
// Self-checking bench for aggregate_writer. A reference model turns
// (base, N, words) into the list of expected (address, byte) memory writes
// and the expected done latency; a monitor records every wr_en cycle.
// Honours AGG_WRITER_CHECKSUM_EN to expect the two checksum bytes.
// -----------------------------------------------------------------------------
module tb_aggregate_writer;

`ifdef AGG_WRITER_CHECKSUM_EN
    localparam int CS_EXTRA = 2;
`else
    localparam int CS_EXTRA = 0;
`endif
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clock;
    logic nrst;

    aggregate_writer_if bus ();

    aggregate_writer dut (
        .clock (clock),
        .nrst  (nrst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [15:0] words [16];
    wr_t         got   [$];
    wr_t         exp_q [$];
    int          rdy_bad  = 0;
    int          busy_bad = 0;

    // Monitor: mid-cycle sampling of the memory write port.
    always @(negedge clock) begin
        if (bus.wr_en === 1'b1) begin
            got.push_back('{addr: bus.address, data: bus.data_out});
            if (bus.data_ready !== 1'b0) rdy_bad++;
            if (bus.busy !== 1'b1) busy_bad++;
        end
        if (bus.done === 1'b1 && bus.busy !== 1'b0) busy_bad++;
    end

    // Reference model: expected byte writes from the writer's rules.
    task automatic build_exp(input logic [15:0] base, input int n);
        int sum;
        int a;
        exp_q.delete();
        sum = 0;
        for (int i = 0; i < n; i++) begin
            a = (int'(base) + 2 * i) % DEPTH;
            exp_q.push_back('{addr: 16'(a), data: words[i][7:0]});
            a = (int'(base) + 2 * i + 1) % DEPTH;
            exp_q.push_back('{addr: 16'(a), data: words[i][15:8]});
            sum = (sum + int'(words[i])) % 65536;
        end
        if (CS_EXTRA != 0) begin
            a = (int'(base) + 2 * n) % DEPTH;
            exp_q.push_back('{addr: 16'(a), data: 8'(sum % 256)});
            a = (int'(base) + 2 * n + 1) % DEPTH;
            exp_q.push_back('{addr: 16'(a), data: 8'(sum / 256)});
        end
    endtask

    function automatic int count_diff();
        int bad;
        bad = (got.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) bad++;
        end
        return bad;
    endfunction

    // Drives one run. Must be entered ~1 time unit after a rising edge.
    // Returns at the negedge of the first done cycle with lat = cycles after
    // E0, -1 on timeout, or -2 after asserting nrst at write byte abort_at.
    // mode < 0: random 0..2 idle WAIT cycles per word; otherwise fixed.
    task automatic do_run(input logic [15:0] base, input int n, input int mode,
                          input int abort_at, output int lat);
        int  wi, write_left, stall_left, wr_seen, budget;
        bit  acc;
        got.delete();
        build_exp(base, n);
        wi = 0; write_left = 0; stall_left = 0; wr_seen = 0;
        lat = -1;
        budget = 6 * n + 20;
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = 8'(n);
        bus.data_valid = 1'b1;
        bus.data_in    = (n > 0) ? words[0] : 16'($urandom);
        @(posedge clock);  // E0
        #1;
        bus.base_addr  = 16'($urandom);  // latched already; must not matter
        bus.word_count = 8'($urandom);
        for (int k = 1; k <= budget; k++) begin
            if (write_left > 0) begin
                write_left--;
                bus.data_valid = 1'($urandom_range(1, 0));
                bus.data_in    = (wi < n) ? words[wi] : 16'($urandom);
            end else if (stall_left > 0) begin
                stall_left--;
                bus.data_valid = 1'b0;
                bus.data_in    = 16'($urandom);
            end else if (wi < n) begin
                bus.data_valid = 1'b1;
                bus.data_in    = words[wi];
            end else begin
                bus.data_valid = 1'($urandom_range(1, 0));
                bus.data_in    = 16'($urandom);
            end
            @(negedge clock);
            if (bus.wr_en === 1'b1) wr_seen++;
            if (abort_at > 0 && wr_seen == abort_at) begin
                nrst = 1'b0;
                bus.start = 1'b0;
                lat = -2;
                return;
            end
            if (bus.done === 1'b1) begin
                lat = k;
                return;
            end
            acc = (bus.data_valid === 1'b1) && (bus.data_ready === 1'b1);
            @(posedge clock);
            #1;
            if (acc) begin
                wi++;
                write_left = 2;
                stall_left = (mode < 0) ? int'($urandom_range(2, 0)) : mode;
            end
        end
    endtask

    // Drop start after done; ends ~1 unit after the edge that enters IDLE.
    task automatic finish_run();
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.data_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.start = 1'b1;
        bus.base_addr = 16'h1234;
        bus.word_count = 8'd3;
        bus.data_in = 16'hA5A5;
        bus.data_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++; if (bus.data_ready !== 1'b0) begin failures++; $display("FAIL reset_data_ready: got %b want 0", bus.data_ready); end
        checks++; if (bus.address !== 16'h0000) begin failures++; $display("FAIL reset_address: got %h want 0000", bus.address); end
        checks++; if (bus.data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
        bus.start = 1'b0;
        bus.data_valid = 1'b0;
        @(posedge clock);
        #1;
        nrst = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        int lat, n_wr, d;
        words[0] = 16'h0001;
        do_run(16'h0000, 1, 0, 0, lat);
        d = count_diff();
        checks++; if (d !== 0) begin failures++; $display("FAIL single_writes: got %0d bytes (%0d bad) want %0d", got.size(), d, exp_q.size()); end
        checks++; if (lat !== 4 + CS_EXTRA) begin failures++; $display("FAIL single_done_latency: got %0d want %0d", lat, 4 + CS_EXTRA); end
        n_wr = got.size();
        // start still high: done must be held and nothing re-latched
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL single_done_held: got %b want 1", bus.done); end
        checks++; if (got.size() !== n_wr) begin failures++; $display("FAIL single_no_rewrite: got %0d bytes want %0d", got.size(), n_wr); end
        finish_run();
        @(negedge clock);
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin failures++; $display("FAIL single_back_to_idle: got done/busy %b want 00", {bus.done, bus.busy}); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_stalls();
        int lat, d;
        words[0] = 16'h1234; words[1] = 16'hABCD; words[2] = 16'hFFFF;
        rdy_bad = 0;
        do_run(16'h0010, 3, 2, 0, lat);
        d = count_diff();
        checks++; if (d !== 0) begin failures++; $display("FAIL stall_writes: got %0d bytes (%0d bad) want %0d", got.size(), d, exp_q.size()); end
        checks++; if (lat !== 14 + CS_EXTRA) begin failures++; $display("FAIL stall_done_latency: got %0d want %0d", lat, 14 + CS_EXTRA); end
        checks++; if (rdy_bad !== 0) begin failures++; $display("FAIL stall_ready_in_write: got %0d cycles want 0", rdy_bad); end
        finish_run();
    endtask

    task automatic test_wrap();
        int lat, d;
        words[0] = 16'hBEEF;
        do_run(16'h03FF, 1, 0, 0, lat);
        d = count_diff();
        checks++; if (d !== 0) begin failures++; $display("FAIL wrap_writes: got %0d bytes (%0d bad) want %0d", got.size(), d, exp_q.size()); end
        checks++; if (got.size() < 2 || got[1].addr !== 16'h0000) begin failures++; $display("FAIL wrap_hi_addr: got %0d bytes want hi byte at 0000", got.size()); end
        finish_run();
    endtask

    task automatic test_zero();
        int lat, d;
        do_run(16'h0123, 0, 0, 0, lat);
        d = count_diff();
        checks++; if (d !== 0) begin failures++; $display("FAIL zero_writes: got %0d bytes (%0d bad) want %0d", got.size(), d, exp_q.size()); end
        checks++; if (lat !== 1 + CS_EXTRA) begin failures++; $display("FAIL zero_done_latency: got %0d want %0d", lat, 1 + CS_EXTRA); end
        finish_run();
    endtask

    task automatic test_checksum_pattern();
        int lat, d;
        words[0] = 16'hFFFF; words[1] = 16'h0002;
        do_run(16'h0200, 2, 0, 0, lat);
        d = count_diff();
        checks++; if (d !== 0) begin failures++; $display("FAIL cs_pattern_writes: got %0d bytes (%0d bad) want %0d", got.size(), d, exp_q.size()); end
        checks++; if (lat !== 7 + CS_EXTRA) begin failures++; $display("FAIL cs_pattern_latency: got %0d want %0d", lat, 7 + CS_EXTRA); end
        finish_run();
    endtask

    task automatic test_random();
        int lat, d, n;
        logic [15:0] base;
        busy_bad = 0;
        rdy_bad = 0;
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(8, 1));
            base = 16'($urandom);
            for (int i = 0; i < n; i++) words[i] = 16'($urandom);
            do_run(base, n, -1, 0, lat);
            d = count_diff();
            checks++; if (d !== 0) begin failures++; $display("FAIL random_writes[%0d]: got %0d bytes (%0d bad) want %0d base %h", r, got.size(), d, exp_q.size(), base); end
            checks++; if (lat < 3 * n + 1 + CS_EXTRA) begin failures++; $display("FAIL random_done[%0d]: got latency %0d want >= %0d", r, lat, 3 * n + 1 + CS_EXTRA); end
            finish_run();
        end
        checks++; if (busy_bad !== 0) begin failures++; $display("FAIL random_busy: got %0d bad cycles want 0", busy_bad); end
        checks++; if (rdy_bad !== 0) begin failures++; $display("FAIL random_ready_in_write: got %0d cycles want 0", rdy_bad); end
    endtask

    task automatic test_reset_mid_run();
        int lat, d;
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        do_run(16'h0040, 4, 0, 4, lat);
        checks++; if (lat !== -2) begin failures++; $display("FAIL midreset_reached_wr_hi: got %0d want -2", lat); end
        @(posedge clock);
        @(negedge clock);
        checks++; if ({bus.data_ready, bus.wr_en, bus.busy, bus.done} !== 4'b0000) begin failures++; $display("FAIL midreset_flags: got %b want 0000", {bus.data_ready, bus.wr_en, bus.busy, bus.done}); end
        checks++; if ({bus.address, bus.data_out} !== 24'h0) begin failures++; $display("FAIL midreset_bus: got %h want 000000", {bus.address, bus.data_out}); end
        @(posedge clock);
        #1;
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
        do_run(16'h0100, 3, 0, 0, lat);
        d = count_diff();
        checks++; if (d !== 0) begin failures++; $display("FAIL midreset_rerun_writes: got %0d bytes (%0d bad) want %0d", got.size(), d, exp_q.size()); end
        checks++; if (lat !== 10 + CS_EXTRA) begin failures++; $display("FAIL midreset_rerun_latency: got %0d want %0d", lat, 10 + CS_EXTRA); end
        finish_run();
    endtask

    initial begin
        nrst = 1'b0;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.word_count = '0;
        bus.data_in = '0;
        bus.data_valid = 1'b0;
        test_reset();
        test_single();
        test_stalls();
        test_wrap();
        test_zero();
        test_checksum_pattern();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aggregate_writer.md
# aggregate_writer

Memory-side writer for the node register bank: on `start`, accepts a run of 16-bit words over a valid/ready handshake and stores each as two consecutive bytes in the 8-bit-wide data memory. It sits in the write direction of the bus that flag/parameter readers use. It stores aggregation results and sensor words at a caller-supplied base address, then signals `done`.

## Interface
- `MEM_DEPTH`, 1024, memory depth in bytes; addresses wrap modulo this value
- `MEM_WIDTH`, 8, memory data width (bits)
- `WORD_WIDTH`, 16, input word and address width (bits)
- `clock`  in  1  sole clock, rising edge
- `nrst`  in  1  reset; synchronous, active-low
- `start`  in  1  level request; sampled only in IDLE
- `base_addr`  in  16  first byte address; latched when start is accepted
- `word_count`  in  8  number of words N to write; latched with start
- `data_in`  in  16  word to store
- `data_valid`  in  1  data_in valid
- `data_ready`  out  1  writer can accept a word
- `address`  out  16  memory byte address
- `data_out`  out  8  memory write byte
- `wr_en`  out  1  memory write strobe, one byte per cycle
- `busy`  out  1  high in any state other than IDLE and DONE
- `done`  out  1  run complete

## Operation
- States: IDLE, WAIT_WORD, WR_LO, WR_HI, DONE; with checksum, also CS_LO and CS_HI.
- IDLE:
  - start=1 latches base_addr and word_count, clears index i, and goes to WAIT_WORD.
  - If word_count=0, it goes to DONE instead, or to CS_LO when checksum is enabled.
- WAIT_WORD: data_ready=1. data_valid&data_ready captures data_in, and the state goes to WR_LO.
- WR_LO: wr_en=1, address=(base+2i) mod MEM_DEPTH, data_out=word[7:0]. Goes to WR_HI.
- WR_HI: wr_en=1, address=(base+2i+1) mod MEM_DEPTH, data_out=word[15:8]. i increments. If i+1=N, goes to DONE or CS_LO; otherwise to WAIT_WORD.
- DONE: done=1, held while start=1. When start=0, returns to IDLE and done drops.
- Address arithmetic: 16-bit add, reduced modulo MEM_DEPTH, zero-extended to 16 bits. A run crossing the top of memory wraps to 0.
- start while busy or in DONE: ignored, no re-latch.
- data_valid outside WAIT_WORD: ignored; the word is not consumed.
- Reset values: data_ready=0, address=0, data_out=0, wr_en=0, busy=0, done=0, state=IDLE, i=0, checksum=0.
- Reset mid-run: the next edge forces reset values. Bytes already written are not undone.

## Timing
- Start is accepted at edge E0; WAIT_WORD is the cycle after E0.
- Each word takes a minimum of 3 cycles: accept, lo byte, hi byte.
- With data_valid held high, done rises 3N+1 cycles after E0, or 3N+3 with checksum. wr_en is high for 2N cycles, or 2N+2.
- Word acceptance is exactly the cycle where data_valid and data_ready are both high.
- Little-endian: the low byte is always written one cycle before the high byte.

## Configuration
- `AGG_WRITER_CHECKSUM_EN` defined:
  - A 16-bit wrap-around sum of all accepted words is accumulated.
  - After the last word, CS_LO writes sum[7:0] at base+2N and CS_HI writes sum[15:8] at base+2N+1, then the state goes to DONE.
  - With N=0, 0x0000 is written at base and base+1.
- Undefined: no checksum states, no accumulator; WR_HI of the last word goes directly to DONE.

## Structure
- Shared package holds MEM_DEPTH/MEM_WIDTH/WORD_WIDTH constants, state encoding, and the register-bank address map (0x0 flag word).
- One sub-module, `checksum16`:
  - clear/accumulate inputs, 16-bit sum output.
  - Instantiated only under `AGG_WRITER_CHECKSUM_EN`.

## Test plan
- N=1, base=0x0000, word 0x0001 → writes 0x01@0x0000 then 0x00@0x0001. done at E0+4.
- N=3, base=0x0010, words 0x1234, 0xABCD, 0xFFFF with valid stalls of 2 cycles between words:
  - Writes 34,12,CD,AB,FF,FF at 0x10–0x15.
  - data_ready is low during the write cycles.
- base=0x03FF, N=1, word 0xBEEF → EF@0x03FF, BE@0x0000 (wrap).
- N=0 → no wr_en; done at E0+1. With checksum: 00@base, 00@base+1, then done.
- Checksum on, words 0xFFFF, 0x0002 → sum 0x0001 written as 01,00 after the payload.
- nrst low during WR_HI of word 2 of 4 → next edge: all outputs 0, state IDLE. A new start then runs a clean sequence.
